// File: rtl/ask_word_feeder_if.sv
// ----------------------------------------------------------------------------
// ask_word_feeder_if
// Payload handshake between a word source and ask_word_feeder.
//   in_data   16  payload word, meaningful while in_valid is high
//   in_valid   1  source offers in_data
//   in_ready   1  sink can take a word this cycle
// A word moves on every clock edge where in_valid && in_ready.
// ----------------------------------------------------------------------------
interface ask_word_feeder_if;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/ask_word_feeder.sv
// ----------------------------------------------------------------------------
// ask_word_feeder
// Upstream word scheduler for the 2ASK transmitter. Buffers 16-bit payload
// words in a first-word-fall-through FIFO and presents each one on data_out
// for a 16-symbol frame followed by an idle gap. The transmitter only starts
// a frame when its data_in changes, so a word equal to the one already on the
// bus is preceded by a single cycle of its complement.
//
// Parameters:
//   SYM_CLKS    clocks per symbol (transmitter B_FREQ + 1)
//   GAP_SYMS    idle symbols after each frame, 0 allowed
//   FIFO_DEPTH  word buffer depth, power of two, >= 2
//
// Ports:
//   sys_clk      in   clock
//   sys_rst_n    in   asynchronous active-low reset
//   in_bus       slave handshake: in_data / in_valid in, in_ready out
//   data_out     out  word bus to the transmitter's data_in
//   frame_start  out  one-cycle pulse when a new payload word lands on data_out
//   busy         out  high whenever the scheduler is not in IDLE
//   fifo_level   out  current FIFO occupancy
// ----------------------------------------------------------------------------
module ask_word_feeder #(
   parameter int SYM_CLKS   = 50,
   parameter int GAP_SYMS   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   ask_word_feeder_if.slave              in_bus,
   output logic [15:0]                   data_out,
   output logic                          frame_start,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   // Counters are loaded with (duration - 1) and the state is left when they
   // read 0, so each state lasts exactly its duration in clocks.
   localparam logic [15:0] SEND_LOAD = 16'(16 * SYM_CLKS - 1);
   localparam logic [15:0] GAP_LOAD  = (GAP_SYMS > 0) ? 16'(GAP_SYMS * SYM_CLKS - 1) : 16'd0;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] TOGGLE = 2'd1;
   localparam logic [1:0] SEND   = 2'd2;
   localparam logic [1:0] GAP    = 2'd3;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [15:0]   head;
   logic          push;
   logic          pop;
   logic [1:0]    state;
   logic [15:0]   cnt;

   // ------------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------------
   // Ready comes from the registered level only: a pop while full frees the
   // slot for the following cycle, never the current one.
   assign in_bus.in_ready = (fifo_level != FULL_LEVEL);
   assign push            = in_bus.in_valid && in_bus.in_ready;
   assign head            = mem[rd_ptr];

   // NOTE: the storage array has no reset; the pointers and level define
   // which entries are meaningful, so clearing them empties the FIFO.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr] <= in_bus.in_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Scheduler
   // ------------------------------------------------------------------------
   // The head is consumed when it goes straight onto the bus from IDLE, or
   // one cycle later after the complement has been shown in TOGGLE.
   // NOTE: pop is given a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:    pop = (fifo_level != '0) && (head != data_out);
         TOGGLE:  pop = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         data_out    <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            IDLE: begin
               if (fifo_level != '0) begin
                  if (head != data_out) begin
                     data_out    <= head;
                     frame_start <= 1'b1;
                     cnt         <= SEND_LOAD;
                     state       <= SEND;
                  end else begin
                     // Same word as on the bus: show its complement for one
                     // cycle so the transmitter sees a change.
                     data_out <= ~head;
                     state    <= TOGGLE;
                  end
               end
            end

            TOGGLE: begin
               data_out    <= head;
               frame_start <= 1'b1;
               cnt         <= SEND_LOAD;
               state       <= SEND;
            end

            SEND: begin
               if (cnt == '0) begin
                  if (GAP_SYMS > 0) begin
                     cnt   <= GAP_LOAD;
                     state <= GAP;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end

            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
